// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV64I core: sequences IF/ID/EX/MEM/WB over a
// shared ALU, handles variable-latency memory with a timeout and counts retirements.
module multicycle_ctrl #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [3:0] {C_NONE, C_R, C_OPI, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_AUIPC, C_ILL} cls_t;

    function automatic cls_t decode(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_OPI;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input cls_t c);
        case (c)
            C_OPI, C_LD, C_JALR: return 3'd0;
            C_ST:                return 3'd1;
            C_BR:                return 3'd2;
            C_AUIPC:             return 3'd3;
            C_JAL:               return 3'd4;
            default:             return 3'd7;
        endcase
    endfunction

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls_s;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic             timeout_s, retire_s;
    logic             imem_req_s, ir_write_s, pc_write_s, dmem_rd_s, dmem_wr_s, reg_write_s;
    logic [1:0]       pc_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, wb_sel_s;
    logic [2:0]       imm_sel_s;

    assign dec_cls_s = decode(opcode);
    // A ready on the last permitted wait cycle still wins, so trap only with ready low here.
    assign timeout_s = (TIMEOUT != 0) && (wait_q == WW'(TIMEOUT - 1));

    // Next-state, control strobes and retire decision for the current phase.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        wait_d      = '0;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        retire_s    = 1'b0;
        imem_req_s  = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc_src_s    = 2'd0;
        alu_src_a_s = 2'd0;
        alu_src_b_s = 2'd0;
        alu_op_s    = 2'd0;
        imm_sel_s   = 3'd7;
        dmem_rd_s   = 1'b0;
        dmem_wr_s   = 1'b0;
        reg_write_s = 1'b0;
        wb_sel_s    = 2'd0;
        case (state_q)
            S_IF: begin
                imem_req_s  = 1'b1;
                alu_src_a_s = 2'd2;
                alu_src_b_s = 2'd2;
                if (imem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_ID;
                end else if (timeout_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_ID: begin
                cls_d       = dec_cls_s;
                imm_sel_s   = imm_of(dec_cls_s);
                alu_src_a_s = 2'd1;
                alu_src_b_s = 2'd1;
                if (dec_cls_s == C_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                imm_sel_s = imm_of(cls_q);
                case (cls_q)
                    C_R: begin
                        alu_op_s = 2'd2;
                        state_d  = S_WB;
                    end
                    C_OPI: begin
                        alu_src_b_s = 2'd1;
                        alu_op_s    = 2'd2;
                        state_d     = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src_b_s = 2'd1;
                        state_d     = S_MEM;
                    end
                    C_BR: begin
                        alu_op_s = 2'd1;
                        if (branch_taken) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = 2'd1;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                        retire_s = 1'b1;
                        state_d  = S_IF;
                    end
                    C_JAL: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'd1;
                        state_d    = S_WB;
                    end
                    C_JALR: begin
                        alu_src_b_s = 2'd1;
                        pc_write_s  = 1'b1;
                        state_d     = S_WB;
                    end
                    C_AUIPC: begin
                        alu_src_a_s = 2'd1;
                        alu_src_b_s = 2'd1;
                        state_d     = S_WB;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                dmem_rd_s = (cls_q == C_LD);
                dmem_wr_s = (cls_q == C_ST);
                if (dmem_ready) begin
                    if (cls_q == C_ST) begin
                        retire_s = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_s) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                reg_write_s = 1'b1;
                if (cls_q == C_LD) begin
                    wb_sel_s = 2'd1;
                end else if ((cls_q == C_JAL) || (cls_q == C_JALR)) begin
                    wb_sel_s = 2'd2;
                end else begin
                    wb_sel_s = 2'd0;
                end
                retire_s = 1'b1;
                state_d  = S_IF;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (retire_s) begin
            instret_d = instret_q + CNT_W'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // State, latched class, wait counter, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            cls_q     <= C_NONE;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Everything reads as idle while reset is held, even before the first edge.
    assign imem_req  = rst_n & imem_req_s;
    assign ir_write  = rst_n & ir_write_s;
    assign pc_write  = rst_n & pc_write_s;
    assign pc_src    = rst_n ? pc_src_s    : 2'd0;
    assign alu_src_a = rst_n ? alu_src_a_s : 2'd0;
    assign alu_src_b = rst_n ? alu_src_b_s : 2'd0;
    assign alu_op    = rst_n ? alu_op_s    : 2'd0;
    assign imm_sel   = rst_n ? imm_sel_s   : 3'd7;
    assign dmem_rd   = rst_n & dmem_rd_s;
    assign dmem_wr   = rst_n & dmem_wr_s;
    assign reg_write = rst_n & reg_write_s;
    assign wb_sel    = rst_n ? wb_sel_s    : 2'd0;
    assign illegal   = rst_n & illegal_q;
    assign bus_err   = rst_n & bus_err_q;
    assign instret   = rst_n ? instret_q   : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction phase model builds the
// expected control trace, random waits/branches/opcodes drive it cycle by cycle.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic          imem_req, ir_write, pc_write, dmem_rd, dmem_wr, reg_write, illegal, bus_err;
    logic [1:0]    pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [2:0]    imm_sel;
    logic [CW-1:0] instret;
    logic [CW-1:0] exp_ret = '0;
    logic [18:0]   act;
    int            errors = 0;
    int            checks = 0;

    typedef struct packed {
        logic        imr;
        logic        dmr;
        logic        brt;
        logic [18:0] e;
        logic [18:0] m;
    } cyc_t;
    cyc_t tr[$];

    multicycle_ctrl #(.CNT_W(CW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal),
        .bus_err(bus_err), .instret(instret)
    );

    assign act = {imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                  imm_sel, dmem_rd, dmem_wr, reg_write, wb_sel};

    always #5 clk = ~clk;

    function automatic logic [18:0] pk(input logic imq, irw, pcw, input logic [1:0] ps, a, b, op,
                                       input logic [2:0] im, input logic rd, wr, rw,
                                       input logic [1:0] wb);
        return {imq, irw, pcw, ps, a, b, op, im, rd, wr, rw, wb};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic void push(input logic imr, dmr, brt, input logic [18:0] e, m);
        cyc_t c;
        c.imr = imr; c.dmr = dmr; c.brt = brt; c.e = e; c.m = m;
        tr.push_back(c);
    endfunction

    // 0 R, 1 OPI, 2 LD, 3 ST, 4 BR, 5 JAL, 6 JALR, 7 AUIPC, 8 illegal
    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            7'b0010111: return 7;
            default:    return 8;
        endcase
    endfunction

    // Expected per-cycle trace of one instruction: iw fetch waits, dw memory waits.
    function automatic void build(input logic [6:0] opc, input logic tk, input int iw, input int dw);
        int          c;
        logic [2:0]  im;
        logic [18:0] m_if, m_ex, m_ps, m_mem, m_wb, ev;
        c = cls_of(opc);
        case (c)
            1, 2, 6: im = 3'd0;
            3:       im = 3'd1;
            4:       im = 3'd2;
            7:       im = 3'd3;
            5:       im = 3'd4;
            default: im = 3'd7;
        endcase
        m_if  = pk(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 2'd3, 2'd3, 3'd0, 1'b1, 1'b1, 1'b1, 2'd0);
        m_ex  = pk(1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 2'd3, 2'd3, 3'd7, 1'b1, 1'b1, 1'b1, 2'd0);
        m_ps  = pk(1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        m_mem = pk(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 2'd0);
        m_wb  = pk(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b1, 2'd3);
        tr.delete();
        for (int i = 0; i < iw; i++)
            push(1'b0, rb(), rb(), pk(1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0), m_if);
        push(1'b1, rb(), rb(), pk(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0), m_if);
        push(rb(), rb(), rb(), pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, im, 1'b0, 1'b0, 1'b0, 2'd0),
             pk(1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 2'd3, 2'd3, (c == 8) ? 3'd0 : 3'd7, 1'b1, 1'b1, 1'b1, 2'd0));
        if (c == 8) return;
        case (c)
            0: ev = pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, im, 1'b0, 1'b0, 1'b0, 2'd0);
            1: ev = pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd2, im, 1'b0, 1'b0, 1'b0, 2'd0);
            4: ev = pk(1'b0, 1'b0, tk, {1'b0, tk}, 2'd0, 2'd0, 2'd1, im, 1'b0, 1'b0, 1'b0, 2'd0);
            5: ev = pk(1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, im, 1'b0, 1'b0, 1'b0, 2'd0);
            6: ev = pk(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd0, im, 1'b0, 1'b0, 1'b0, 2'd0);
            7: ev = pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, im, 1'b0, 1'b0, 1'b0, 2'd0);
            default: ev = pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, im, 1'b0, 1'b0, 1'b0, 2'd0);
        endcase
        if (c == 5) m_ex = pk(1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0, 2'd0, 3'd7, 1'b1, 1'b1, 1'b1, 2'd0);
        else if (c == 6 || (c == 4 && tk)) m_ex = m_ex | m_ps;
        push(rb(), rb(), (c == 4) ? tk : rb(), ev, m_ex);
        if (c == 2 || c == 3) begin
            ev = pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, c == 2, c == 3, 1'b0, 2'd0);
            for (int i = 0; i < dw; i++) push(rb(), 1'b0, rb(), ev, m_mem);
            push(rb(), 1'b1, rb(), ev, m_mem);
        end
        if (c != 3 && c != 4)
            push(rb(), rb(), rb(), pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1,
                 (c == 2) ? 2'd1 : ((c == 5 || c == 6) ? 2'd2 : 2'd0)), m_wb);
    endfunction

    task automatic drive(input cyc_t c, input logic [6:0] opc);
        @(negedge clk);
        opcode = opc; imem_ready = c.imr; dmem_ready = c.dmr; branch_taken = c.brt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        rst_n = 1'b1;
        imem_ready = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_reset();
        imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1; opcode = 7'b0110011;
        @(negedge clk);
        #1;
        checks++;
        if ({act, instret, illegal, bus_err} !==
            {pk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd7, 1'b0, 1'b0, 1'b0, 2'd0), {CW{1'b0}}, 2'b00}) begin
            errors++;
            $display("FAIL reset_hold outputs=%h instret=%0d ill=%b berr=%b, want all idle imm_sel=7", act, instret, illegal, bus_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_ready = 1'b0;
        #1;
        checks++;
        if ({imem_req, ir_write, pc_write, reg_write, instret} !== {4'b1000, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_release req/irw/pcw/rw=%b%b%b%b instret=%0d, want 1000 and 0", imem_req, ir_write, pc_write, reg_write, instret);
        end
    endtask

    task automatic test_directed();
        logic [6:0] ops [9];
        logic       tks [9];
        int         dws [9];
        ops = '{7'b0110011, 7'b1100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0010111, 7'b0000011, 7'b0100011};
        tks = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        dws = '{0, 0, 0, 0, 0, 0, 0, 3, 0};
        for (int n = 0; n < 9; n++) begin
            build(ops[n], tks[n], 0, dws[n]);
            foreach (tr[k]) begin
                drive(tr[k], ops[n]);
                checks++;
                if (((act & tr[k].m) !== (tr[k].e & tr[k].m)) || (instret !== exp_ret)) begin
                    errors++;
                    $display("FAIL directed op=%b cyc=%0d got=%h want=%h instret=%0d want=%0d", ops[n], k, act & tr[k].m, tr[k].e & tr[k].m, instret, exp_ret);
                end
            end
            @(posedge clk);
            #1;
            exp_ret = exp_ret + 1'b1;
            checks++;
            if (instret !== exp_ret) begin
                errors++;
                $display("FAIL directed_retire op=%b instret=%0d want=%0d", ops[n], instret, exp_ret);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] legal [8];
        logic [6:0] op;
        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111};
        for (int n = 0; n < 22; n++) begin
            op = legal[$urandom_range(7)];
            build(op, rb(), $urandom_range(3), $urandom_range(3));
            foreach (tr[k]) begin
                drive(tr[k], op);
                checks++;
                if (((act & tr[k].m) !== (tr[k].e & tr[k].m)) || (instret !== exp_ret)) begin
                    errors++;
                    $display("FAIL b2b op=%b cyc=%0d got=%h want=%h instret=%0d want=%0d", op, k, act & tr[k].m, tr[k].e & tr[k].m, instret, exp_ret);
                end
            end
            @(posedge clk);
            #1;
            exp_ret = exp_ret + 1'b1;
            checks++;
            if (instret !== exp_ret) begin
                errors++;
                $display("FAIL b2b_retire op=%b instret=%0d want=%0d", op, instret, exp_ret);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        build(7'b0100011, 1'b0, 0, 3);
        while (tr.size() > 4) void'(tr.pop_back());
        foreach (tr[k]) begin
            drive(tr[k], 7'b0100011);
            checks++;
            if ((act & tr[k].m) !== (tr[k].e & tr[k].m)) begin
                errors++;
                $display("FAIL store_pre_reset cyc=%0d got=%h want=%h", k, act & tr[k].m, tr[k].e & tr[k].m);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_wr, instret} !== {1'b0, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL store_reset_hold dmem_wr=%b instret=%0d want 0 0", dmem_wr, instret);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_ret = '0;
        #1;
        checks++;
        if ({imem_req, dmem_wr, dmem_rd, reg_write, instret, illegal, bus_err} !== {4'b1000, {CW{1'b0}}, 2'b00}) begin
            errors++;
            $display("FAIL store_reset_after req=%b wr=%b rd=%b rw=%b instret=%0d ill=%b berr=%b", imem_req, dmem_wr, dmem_rd, reg_write, instret, illegal, bus_err);
        end
    endtask

    task automatic test_timeout();
        cyc_t c;
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 0) begin
                build(7'b0110011, 1'b0, 3, 0);
                c = tr[3]; c.imr = 1'b0; c.e = tr[0].e; tr[3] = c;
                while (tr.size() > 4) void'(tr.pop_back());
            end else if (pass == 1) begin
                build(7'b0110011, 1'b0, 3, 0);
            end else begin
                build(7'b0000011, 1'b0, 0, 3);
                void'(tr.pop_back());
                c = tr[tr.size() - 1]; c.dmr = 1'b0; tr[tr.size() - 1] = c;
            end
            foreach (tr[k]) begin
                drive(tr[k], (pass == 2) ? 7'b0000011 : 7'b0110011);
                checks++;
                if (((act & tr[k].m) !== (tr[k].e & tr[k].m)) || (instret !== exp_ret)) begin
                    errors++;
                    $display("FAIL timeout_p%0d cyc=%0d got=%h want=%h instret=%0d", pass, k, act & tr[k].m, tr[k].e & tr[k].m, instret);
                end
            end
            if (pass == 1) begin
                @(posedge clk);
                #1;
                exp_ret = exp_ret + 1'b1;
                checks++;
                if ({instret, bus_err} !== {exp_ret, 1'b0}) begin
                    errors++;
                    $display("FAIL timeout_ready_wins instret=%0d berr=%b want %0d 0", instret, bus_err, exp_ret);
                end
            end else begin
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = rb();
                    #1;
                    checks++;
                    if ({imem_req, ir_write, pc_write, dmem_rd, dmem_wr, reg_write, bus_err, illegal, instret} !== {6'b0, 2'b10, exp_ret}) begin
                        errors++;
                        $display("FAIL timeout_trap_p%0d strobes=%b%b%b%b%b%b berr=%b ill=%b instret=%0d", pass, imem_req, ir_write, pc_write, dmem_rd, dmem_wr, reg_write, bus_err, illegal, instret);
                    end
                end
                do_reset();
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] op;
        for (int n = 0; n < 3; n++) begin
            if (n == 0) op = 7'b1111111;
            else begin
                op = 7'($urandom);
                while (cls_of(op) != 8) op = 7'($urandom);
            end
            build(op, 1'b0, n, 0);
            foreach (tr[k]) begin
                drive(tr[k], op);
                checks++;
                if ((act & tr[k].m) !== (tr[k].e & tr[k].m)) begin
                    errors++;
                    $display("FAIL illegal_seq op=%b cyc=%0d got=%h want=%h", op, k, act & tr[k].m, tr[k].e & tr[k].m);
                end
            end
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                imem_ready = rb(); dmem_ready = rb(); branch_taken = rb(); opcode = 7'($urandom);
                #1;
                checks++;
                if ({imem_req, ir_write, pc_write, dmem_rd, dmem_wr, reg_write, illegal, bus_err, instret} !== {6'b0, 2'b10, exp_ret}) begin
                    errors++;
                    $display("FAIL illegal_trap op=%b cyc=%0d strobes=%b%b%b%b%b%b ill=%b berr=%b instret=%0d", op, j, imem_req, ir_write, pc_write, dmem_rd, dmem_wr, reg_write, illegal, bus_err, instret);
                end
            end
            do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_store();
        test_timeout();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
